// File: rtl/audio_sample_fifo.sv
// Captures one sample per fs_i pulse on its falling edge into a first-word-fall-through FIFO (1-cycle write-to-valid).
// Tracks dropped samples and peak magnitude; the consumer stalls with m_tready; captures arriving while full are dropped unless a pop frees a slot that cycle.
module audio_sample_fifo #(
  parameter int DEPTH = 16,
  parameter int DW    = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     enable_i,
  input  logic                     fs_i,
  input  logic [DW-1:0]            data_i,
  output logic [DW-1:0]            m_tdata,
  output logic                     m_tvalid,
  input  logic                     m_tready,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     overflow_o,
  output logic [7:0]               drop_cnt_o,
  input  logic                     clr_ovf_i,
  output logic [DW-1:0]            peak_o,
  input  logic                     peak_clr_i
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          fs_q;
  logic          fall;
  logic          cap;
  logic          empty;
  logic          full;
  logic          pop;
  logic          push;
  logic          drop;
  logic [DW-1:0] mag;

  assign fall  = fs_q & ~fs_i;
  assign cap   = fall & enable_i;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = ~empty & m_tready;
  // A pop in the same cycle frees the head slot, so a full FIFO can still accept.
  assign push  = cap & (~full | pop);
  assign drop  = cap & full & ~pop;

  // Two's-complement magnitude kept in DW unsigned bits, so the most negative value maps to 2^(DW-1).
  assign mag = data_i[DW-1] ? ((~data_i) + {{(DW-1){1'b0}}, 1'b1}) : data_i;

  assign m_tvalid = ~empty;
  assign m_tdata  = empty ? '0 : mem[rd_ptr[AW-1:0]];
  assign level_o  = wr_ptr - rd_ptr;

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      fs_q   <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      fs_q <= fs_i;
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // A clear coinciding with a drop still records that drop.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      overflow_o <= 1'b0;
      drop_cnt_o <= 8'd0;
    end else if (clr_ovf_i) begin
      overflow_o <= drop;
      drop_cnt_o <= drop ? 8'd1 : 8'd0;
    end else if (drop) begin
      overflow_o <= 1'b1;
      if (drop_cnt_o != 8'hFF) begin
        drop_cnt_o <= drop_cnt_o + 8'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      peak_o <= '0;
    end else if (peak_clr_i) begin
      peak_o <= cap ? mag : '0;
    end else if (cap && (mag > peak_o)) begin
      peak_o <= mag;
    end
  end

endmodule

// File: tb/tb_audio_sample_fifo.sv
// Directed bench for audio_sample_fifo with a queue-based reference model checked every cycle.
module tb_audio_sample_fifo;
  localparam int DEPTH = 16;
  localparam int DW    = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          enable = 1'b0;
  logic          fs = 1'b0;
  logic [DW-1:0] data = '0;
  logic          m_tready = 1'b0;
  logic          clr_ovf = 1'b0;
  logic          peak_clr = 1'b0;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid;
  logic [4:0]    level;
  logic          overflow;
  logic [7:0]    drop_cnt;
  logic [DW-1:0] peak;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] q[$];
  logic [DW-1:0] pops[$];
  int            m_drop = 0;
  bit            m_ovf = 1'b0;
  int            m_peak = 0;
  bit            m_prev_fs = 1'b0;

  audio_sample_fifo #(.DEPTH(DEPTH), .DW(DW)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .enable_i(enable), .fs_i(fs), .data_i(data),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .level_o(level),
    .overflow_o(overflow), .drop_cnt_o(drop_cnt), .clr_ovf_i(clr_ovf),
    .peak_o(peak), .peak_clr_i(peak_clr)
  );

  always #5 clk = ~clk;

  function automatic int mag_of(input logic [DW-1:0] d);
    return d[DW-1] ? ((1 << DW) - int'(d)) : int'(d);
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one capture per falling strobe, plain queue for storage.
  always @(posedge clk or negedge rst_n) begin : model
    bit fall_m, cap_m, pop_m, drop_m;
    int sz, mg;
    if (!rst_n) begin
      q.delete();
      m_drop = 0;
      m_ovf = 1'b0;
      m_peak = 0;
      m_prev_fs = 1'b0;
    end else begin
      fall_m = m_prev_fs && !fs;
      m_prev_fs = fs;
      cap_m = fall_m && enable;
      sz = q.size();
      pop_m = (sz > 0) && m_tready;
      drop_m = 1'b0;
      mg = mag_of(data);
      if (peak_clr) m_peak = cap_m ? mg : 0;
      else if (cap_m && mg > m_peak) m_peak = mg;
      if (pop_m) void'(q.pop_front());
      if (cap_m) begin
        if (sz < DEPTH || pop_m) q.push_back(data);
        else drop_m = 1'b1;
      end
      if (clr_ovf) begin
        m_ovf = drop_m;
        m_drop = drop_m ? 1 : 0;
      end else if (drop_m) begin
        m_ovf = 1'b1;
        if (m_drop < 255) m_drop++;
      end
    end
  end

  always @(posedge clk) begin
    if (rst_n && m_tvalid && m_tready) pops.push_back(m_tdata);
  end

  always @(negedge clk) begin
    check("valid", m_tvalid, q.size() != 0);
    check("level", level, q.size());
    if (q.size() != 0) check("tdata", m_tdata, q[0]);
    check("overflow", overflow, m_ovf);
    check("drop_cnt", drop_cnt, m_drop);
    check("peak", peak, m_peak);
  end

  task automatic idle(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  // Strobe high for hi edges, then the fall cycle carrying d; returns just after the capturing edge.
  task automatic pulse(input int hi, input logic [DW-1:0] d, input bit pclr, input bit rdy_fall);
    logic old_rdy;
    old_rdy = m_tready;
    fs = 1'b1;
    idle(hi);
    fs = 1'b0;
    data = d;
    peak_clr = pclr;
    if (rdy_fall) m_tready = 1'b1;
    idle(1);
    peak_clr = 1'b0;
    m_tready = old_rdy;
  endtask

  task automatic drain();
    m_tready = 1'b1;
    for (int i = 0; i < 64 && m_tvalid; i++) idle(1);
    check("drain_empty", m_tvalid, 0);
    m_tready = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] vals [3];
    vals[0] = 16'h0001; vals[1] = 16'hFFFF; vals[2] = 16'h7FFF;
    #2 rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_level", level, 0);
    check("rst_valid", m_tvalid, 0);
    rst_n = 1'b1;
    idle(2);

    // Three long pulses, consumer always ready.
    enable = 1'b1;
    m_tready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pulse(32, vals[i], 1'b0, 1'b0);
      check("t1_valid_latency", m_tvalid, 1);
      check("t1_head", m_tdata, vals[i]);
      idle(967);
    end
    check("t1_pop_count", pops.size(), 3);
    for (int i = 0; i < 3; i++) check("t1_pop_order", pops[i], vals[i]);
    check("t1_peak", peak, 16'h7FFF);
    peak_clr = 1'b1;
    idle(1);
    peak_clr = 1'b0;
    check("peak_clear_idle", peak, 0);

    // Held-high strobe makes no capture; a fall while disabled is lost silently.
    m_tready = 1'b0;
    enable = 1'b0;
    fs = 1'b1;
    idle(20);
    check("held_high_level", level, 0);
    fs = 1'b0;
    data = 16'h1234;
    idle(3);
    check("disabled_level", level, 0);
    check("disabled_drops", drop_cnt, 0);
    enable = 1'b1;

    // Overflow with consumer stalled.
    pops.delete();
    for (int i = 0; i < DEPTH + 3; i++) begin
      pulse(3, 16'(16'h0100 + i), 1'b0, 1'b0);
      idle(1);
    end
    check("t2_level", level, 16);
    check("t2_overflow", overflow, 1);
    check("t2_drops", drop_cnt, 3);
    drain();
    check("t2_pop_count", pops.size(), 16);
    for (int i = 0; i < 16; i++) check("t2_pop_data", pops[i], 16'(16'h0100 + i));
    clr_ovf = 1'b1;
    idle(1);
    clr_ovf = 1'b0;
    check("t2_clr_ovf", overflow, 0);
    check("t2_clr_drops", drop_cnt, 0);

    // Full FIFO, capture and pop in the same cycle.
    for (int i = 0; i < DEPTH; i++) begin
      pulse(3, 16'(16'h0200 + i), 1'b0, 1'b0);
      idle(1);
    end
    check("t3_full_level", level, 16);
    pops.delete();
    pulse(3, 16'h02AA, 1'b0, 1'b1);
    check("t3_level_kept", level, 16);
    check("t3_no_drop", drop_cnt, 0);
    check("t3_no_ovf", overflow, 0);
    drain();
    check("t3_pop_count", pops.size(), 17);
    check("t3_first", pops[0], 16'h0200);
    check("t3_second", pops[1], 16'h0201);
    check("t3_last", pops[16], 16'h02AA);

    // Peak tracking and clear coincident with a capture.
    m_tready = 1'b1;
    peak_clr = 1'b1;
    idle(1);
    peak_clr = 1'b0;
    pulse(3, 16'h1000, 1'b0, 1'b0); idle(2);
    pulse(3, 16'h8000, 1'b0, 1'b0); idle(2);
    pulse(3, 16'h7FFF, 1'b0, 1'b0); idle(2);
    check("t4_peak_before", peak, 16'h8000);
    pulse(3, 16'h0005, 1'b1, 1'b0);
    check("t4_peak_after", peak, 16'h0005);
    idle(2);
    drain();

    // Drop counter saturation, clear, and clear coincident with a drop.
    for (int i = 0; i < DEPTH + 300; i++) begin
      pulse(1, 16'(i), 1'b0, 1'b0);
      idle(1);
    end
    check("t5_drops_sat", drop_cnt, 255);
    check("t5_overflow", overflow, 1);
    clr_ovf = 1'b1;
    idle(1);
    clr_ovf = 1'b0;
    check("t5_clr_ovf", overflow, 0);
    check("t5_clr_drops", drop_cnt, 0);
    fs = 1'b1;
    idle(2);
    fs = 1'b0;
    data = 16'h0777;
    clr_ovf = 1'b1;
    idle(1);
    clr_ovf = 1'b0;
    check("t5_clr_with_drop_ovf", overflow, 1);
    check("t5_clr_with_drop_cnt", drop_cnt, 1);
    clr_ovf = 1'b1;
    idle(1);
    clr_ovf = 1'b0;
    drain();

    // Reset mid-operation with samples queued and strobe high.
    for (int i = 0; i < 5; i++) begin
      pulse(3, 16'(16'h0300 + i), 1'b0, 1'b0);
      idle(1);
    end
    check("t6_level_before", level, 5);
    fs = 1'b1;
    idle(3);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_valid", m_tvalid, 0);
    check("t6_rst_level", level, 0);
    check("t6_rst_tdata", m_tdata, 0);
    check("t6_rst_ovf", overflow, 0);
    check("t6_rst_drops", drop_cnt, 0);
    check("t6_rst_peak", peak, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(3);
    check("t6_no_capture_yet", level, 0);
    fs = 1'b0;
    data = 16'h0ABC;
    idle(1);
    check("t6_level_after", level, 1);
    check("t6_head_after", m_tdata, 16'h0ABC);
    drain();
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
